// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - demand-actuated NS/EW phase scheduler with ped latches
module traffic_phase_scheduler #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 3,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             car_ns,
  input  logic             car_ew,
  input  logic             ped_ns_btn,
  input  logic             ped_ew_btn,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk_ns,
  output logic             walk_ew,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] timer_o
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } state_t;

  localparam logic [2:0]       RED    = 3'b100;
  localparam logic [2:0]       YELLOW = 3'b010;
  localparam logic [2:0]       GREEN  = 3'b001;
  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_L  = CNT_W'(WALK_T);

  logic [2:0]       state_r;
  logic [CNT_W-1:0] timer;
  logic             ped_ns_pend, ped_ew_pend;
  logic             walk_grant_ns, walk_grant_ew;
  state_t           next_state;
  logic             go;
  logic             dem_ns, dem_ew;
  logic             enter_ns, enter_ew, leave_ns, leave_ew;

  assign dem_ns = car_ns | ped_ns_pend;
  assign dem_ew = car_ew | ped_ew_pend;

  // go marks a transition this clk; illegal encodings recover without waiting for a tick
  always_comb begin
    go         = 1'b0;
    next_state = ALLRED_A;
    ns_light   = RED;
    ew_light   = RED;
    case (state_r)
      NS_GREEN: begin
        ns_light   = GREEN;
        next_state = NS_YELLOW;
        go = tick & (timer >= GMIN_M1) & dem_ew & (~car_ns | (timer >= GMAX_M1));
      end
      NS_YELLOW: begin
        ns_light   = YELLOW;
        next_state = ALLRED_A;
        go = tick & (timer == YEL_M1);
      end
      ALLRED_A: begin
        next_state = EW_GREEN;
        go = tick & (timer == AR_M1);
      end
      EW_GREEN: begin
        ew_light   = GREEN;
        next_state = EW_YELLOW;
        go = tick & (timer >= GMIN_M1) & dem_ns & (~car_ew | (timer >= GMAX_M1));
      end
      EW_YELLOW: begin
        ew_light   = YELLOW;
        next_state = ALLRED_B;
        go = tick & (timer == YEL_M1);
      end
      ALLRED_B: begin
        next_state = NS_GREEN;
        go = tick & (timer == AR_M1);
      end
      default: begin
        next_state = ALLRED_A;
        go         = 1'b1;
      end
    endcase
  end

  assign enter_ns = go & (next_state == NS_GREEN);
  assign enter_ew = go & (next_state == EW_GREEN);
  assign leave_ns = go & (state_r == NS_GREEN);
  assign leave_ew = go & (state_r == EW_GREEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= NS_GREEN;
      timer   <= '0;
    end else if (go) begin
      state_r <= next_state;
      timer   <= '0;
    end else if (tick && timer != '1) begin
      timer <= timer + 1'b1;
    end
  end

  // a press on the entry clk survives the clear so it is served next green
  always_ff @(posedge clk) begin
    if (reset) begin
      ped_ns_pend   <= 1'b0;
      ped_ew_pend   <= 1'b0;
      walk_grant_ns <= 1'b0;
      walk_grant_ew <= 1'b0;
    end else begin
      if (ped_ns_btn)    ped_ns_pend <= 1'b1;
      else if (enter_ns) ped_ns_pend <= 1'b0;
      if (ped_ew_btn)    ped_ew_pend <= 1'b1;
      else if (enter_ew) ped_ew_pend <= 1'b0;
      if (enter_ns)      walk_grant_ns <= ped_ns_pend;
      else if (leave_ns) walk_grant_ns <= 1'b0;
      if (enter_ew)      walk_grant_ew <= ped_ew_pend;
      else if (leave_ew) walk_grant_ew <= 1'b0;
    end
  end

  assign walk_ns = (state_r == NS_GREEN) & walk_grant_ns & (timer < WALK_L);
  assign walk_ew = (state_r == EW_GREEN) & walk_grant_ew & (timer < WALK_L);
  assign state_o = state_r;
  assign timer_o = timer;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - directed self-checking bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset, tick, car_ns, car_ew, ped_ns_btn, ped_ew_btn;
  logic [2:0] ns_light, ew_light, state_o;
  logic       walk_ns, walk_ew;
  logic [3:0] timer_o;
  int         checks = 0;
  int         failures = 0;

  traffic_phase_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .car_ns(car_ns), .car_ew(car_ew),
    .ped_ns_btn(ped_ns_btn), .ped_ew_btn(ped_ew_btn), .ns_light(ns_light),
    .ew_light(ew_light), .walk_ns(walk_ns), .walk_ew(walk_ew),
    .state_o(state_o), .timer_o(timer_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one tick-qualified clk followed by three idle clks; returns at a negedge
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic chk_st(input string tag, input logic [2:0] st, input logic [3:0] tm,
                        input logic [2:0] ns, input logic [2:0] ew);
    chk({tag, "_state"}, 8'(state_o), 8'(st));
    chk({tag, "_timer"}, 8'(timer_o), 8'(tm));
    chk({tag, "_ns"}, 8'(ns_light), 8'(ns));
    chk({tag, "_ew"}, 8'(ew_light), 8'(ew));
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; car_ns = 1'b0; car_ew = 1'b0;
    ped_ns_btn = 1'b0; ped_ew_btn = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_st("rst", 3'd0, 4'd0, 3'b001, 3'b100);
    chk("rst_walk", {6'd0, walk_ns, walk_ew}, 8'd0);

    // idle: NS rests, timer saturates at 15
    ticks(40);
    chk_st("idle", 3'd0, 4'd15, 3'b001, 3'b100);

    // EW car only
    do_reset();
    car_ew = 1'b1;
    ticks(3);  chk_st("ew_g3", 3'd0, 4'd3, 3'b001, 3'b100);
    ticks(1);  chk_st("ew_y", 3'd1, 4'd0, 3'b010, 3'b100);
    ticks(1);  chk_st("ew_y1", 3'd1, 4'd1, 3'b010, 3'b100);
    ticks(1);  chk_st("ew_ar", 3'd2, 4'd0, 3'b100, 3'b100);
    ticks(2);  chk_st("ew_g", 3'd3, 4'd0, 3'b100, 3'b001);
    ticks(20); chk_st("ew_rest", 3'd3, 4'd15, 3'b100, 3'b001);

    // both cars: 10/2/2 per side, 28-tick cycle
    do_reset();
    car_ns = 1'b1;
    ticks(9);  chk_st("bo_ng9", 3'd0, 4'd9, 3'b001, 3'b100);
    ticks(1);  chk_st("bo_ny", 3'd1, 4'd0, 3'b010, 3'b100);
    ticks(4);  chk_st("bo_eg", 3'd3, 4'd0, 3'b100, 3'b001);
    ticks(9);  chk_st("bo_eg9", 3'd3, 4'd9, 3'b100, 3'b001);
    ticks(1);  chk_st("bo_ey", 3'd4, 4'd0, 3'b100, 3'b010);
    ticks(2);  chk_st("bo_arb", 3'd5, 4'd0, 3'b100, 3'b100);
    ticks(1);  chk_st("bo_arb1", 3'd5, 4'd1, 3'b100, 3'b100);
    ticks(1);  chk_st("bo_cyc", 3'd0, 4'd0, 3'b001, 3'b100);
    car_ns = 1'b0; car_ew = 1'b0;

    // EW pedestrian, no cars
    do_reset();
    @(negedge clk) ped_ew_btn = 1'b1;
    @(negedge clk) ped_ew_btn = 1'b0;
    chk("pe_pend", 8'(dut.ped_ew_pend), 8'd1);
    ticks(3);  chk_st("pe_g3", 3'd0, 4'd3, 3'b001, 3'b100);
    ticks(1);  chk_st("pe_y", 3'd1, 4'd0, 3'b010, 3'b100);
    ticks(4);  chk_st("pe_eg", 3'd3, 4'd0, 3'b100, 3'b001);
    chk("pe_walk0", 8'(walk_ew), 8'd1);
    chk("pe_clr", 8'(dut.ped_ew_pend), 8'd0);
    ticks(2);  chk("pe_walk2", 8'(walk_ew), 8'd1);
    ticks(1);  chk("pe_walk3", 8'(walk_ew), 8'd0);
    ticks(10); chk_st("pe_rest", 3'd3, 4'd13, 3'b100, 3'b001);
    chk("pe_walkns", 8'(walk_ns), 8'd0);

    // NS pedestrian pressed during NS green waits for the next NS green
    do_reset();
    car_ew = 1'b1;
    ticks(1);
    @(negedge clk) ped_ns_btn = 1'b1;
    @(negedge clk) ped_ns_btn = 1'b0;
    ticks(2);  chk("pn_now", 8'(walk_ns), 8'd0);
    chk_st("pn_g3", 3'd0, 4'd3, 3'b001, 3'b100);
    ticks(5);  chk_st("pn_eg", 3'd3, 4'd0, 3'b100, 3'b001);
    ticks(9);  chk_st("pn_eg9", 3'd3, 4'd9, 3'b100, 3'b001);
    ticks(5);  chk_st("pn_ng", 3'd0, 4'd0, 3'b001, 3'b100);
    chk("pn_walk0", 8'(walk_ns), 8'd1);
    ticks(2);  chk("pn_walk2", 8'(walk_ns), 8'd1);
    ticks(1);  chk("pn_walk3", 8'(walk_ns), 8'd0);

    // reset during EW_YELLOW discards pending requests
    do_reset();
    car_ew = 1'b1;
    ticks(8);  chk("ry_eg", 8'(state_o), 8'd3);
    car_ew = 1'b0; car_ns = 1'b1;
    ticks(4);  chk_st("ry_ey", 3'd4, 4'd0, 3'b100, 3'b010);
    @(negedge clk) ped_ew_btn = 1'b1;
    @(negedge clk) ped_ew_btn = 1'b0; reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk_st("ry_rst", 3'd0, 4'd0, 3'b001, 3'b100);
    chk("ry_walk", {6'd0, walk_ns, walk_ew}, 8'd0);
    chk("ry_pend", 8'(dut.ped_ew_pend), 8'd0);
    car_ns = 1'b0;

    // illegal encoding recovers to ALLRED_A without a tick
    @(negedge clk) force dut.state_r = 3'd7;
    #1 release dut.state_r;
    chk("il_state", 8'(state_o), 8'd7);
    chk("il_lights", {2'd0, ns_light, ew_light}, {2'd0, 3'b100, 3'b100});
    @(negedge clk);
    chk_st("il_rec", 3'd2, 4'd0, 3'b100, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
